hdmi_line_fetch: RTL and testbench

Sequences line prefetch into the 512x32 / 1024x16 HDMI line buffer.
- Buffer is split into two 256-word halves (ping-pong); half select is write address bit 8 and read address bit 9.
- On video timing strobes, the block issues one burst read per line to the memory controller and streams the returned words into the half not being displayed.
- It tells the pixel-read side which half to read and flags lines whose fetch did not finish in time.

---
 rtl/hdmi_line_fetch_if.sv | 39 +++
 rtl/hdmi_line_fetch.sv | 136 +++++++++++++
 tb/tb_hdmi_line_fetch.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_line_fetch_if.sv
// Burst-read request/data bus plus line-buffer write port
// of the HDMI line prefetcher.
interface hdmi_line_fetch_if #(
  parameter int ADDR_W = 24
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_len;
  logic [31:0]       mem_data;
  logic              mem_data_valid;
  logic [8:0]        buf_waddr;
  logic [31:0]       buf_wdata;
  logic              buf_wren;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_len,
    input  mem_ready,
    input  mem_data,
    input  mem_data_valid,
    output buf_waddr,
    output buf_wdata,
    output buf_wren
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_len,
    output mem_ready,
    output mem_data,
    output mem_data_valid,
    input  buf_waddr,
    input  buf_wdata,
    input  buf_wren
  );
endinterface

// File: rtl/hdmi_line_fetch.sv
// Ping-pong line prefetch: one burst per line into the
// buffer half not being displayed.
module hdmi_line_fetch #(
  parameter int ADDR_W     = 24,
  parameter int LINE_WORDS = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic [ADDR_W-1:0] fb_base,
  input  logic [ADDR_W-1:0] line_stride,
  hdmi_line_fetch_if.master bus,
  output logic              rd_half,
  output logic              busy,
  output logic              underrun
);

  localparam logic [8:0] LAST = 9'(LINE_WORDS);
  localparam logic [7:0] LEN  = 8'(LINE_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DATA
  } state_t;

  state_t state_q;
  state_t state_d;

  logic              wr_half;
  logic              frame_pend;
  logic [ADDR_W-1:0] line_addr;
  logic [8:0]        cnt;

  logic              frame_evt;
  logic              hs;
  logic              beat;
  logic              done;
  logic              idle_frame;
  logic              idle_line;
  logic              busy_frame;

  logic [8:0]        waddr_q;
  logic [31:0]       wdata_q;
  logic              wren_q;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    hs         = 1'b0;
    beat       = 1'b0;
    done       = 1'b0;
    frame_evt  = frame_start | frame_pend;
    idle_frame = 1'b0;
    idle_line  = 1'b0;
    busy_frame = 1'b0;
    unique case (state_q)
      IDLE: begin
        idle_frame = frame_evt;
        idle_line  = ~frame_evt & line_start;
        if (frame_evt || line_start)
          state_d = REQ;
      end
      REQ: begin
        busy_frame = frame_start;
        hs         = bus.mem_ready;
        if (hs) state_d = DATA;
      end
      DATA: begin
        busy_frame = frame_start;
        // last beat already written once cnt hits LAST
        done = (cnt == LAST);
        beat = bus.mem_data_valid & ~done;
        if (done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_half    <= 1'b0;
      rd_half    <= 1'b0;
      frame_pend <= 1'b0;
      line_addr  <= '0;
      cnt        <= '0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wren_q     <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      wren_q   <= beat;
      underrun <= line_start & busy;
      if (hs) begin
        cnt <= '0;
      end else if (beat) begin
        cnt <= cnt + 9'd1;
      end
      if (beat) begin
        waddr_q <= {wr_half, cnt[7:0]};
        wdata_q <= bus.mem_data;
      end
      unique case (1'b1)
        idle_frame: begin
          line_addr  <= fb_base;
          wr_half    <= 1'b0;
          frame_pend <= 1'b0;
        end
        idle_line: begin
          rd_half   <= wr_half;
          wr_half   <= ~wr_half;
          line_addr <= line_addr + line_stride;
        end
        busy_frame: begin
          frame_pend <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign bus.mem_valid = (state_q == REQ);
  assign bus.mem_addr  = line_addr;
  assign bus.mem_len   = LEN;
  assign bus.buf_waddr = waddr_q;
  assign bus.buf_wdata = wdata_q;
  assign bus.buf_wren  = wren_q;

endmodule

// File: tb/tb_hdmi_line_fetch.sv
// Directed bench for hdmi_line_fetch: frame/line fetch,
// underrun, pending frame, strobe collision, gaps, reset.
module tb_hdmi_line_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_start = 1'b0;
  logic        line_start = 1'b0;
  logic [23:0] fb_base = '0;
  logic [23:0] line_stride = '0;
  logic        rd_half;
  logic        busy;
  logic        underrun;

  int checks = 0;
  int errors = 0;

  hdmi_line_fetch_if #(.ADDR_W(24)) bus ();

  hdmi_line_fetch #(
    .ADDR_W(24),
    .LINE_WORDS(256)
  ) dut (
    .clk(clk),
    .rst(rst),
    .frame_start(frame_start),
    .line_start(line_start),
    .fb_base(fb_base),
    .line_stride(line_stride),
    .bus(bus),
    .rd_half(rd_half),
    .busy(busy),
    .underrun(underrun)
  );

  always #5 clk = ~clk;

  // Entered right after the strobe was driven on a negedge.
  // Writes trail their beat by one cycle; busy clears one
  // cycle after the final write.
  task automatic burst(input logic [23:0] a, input logic h,
                       input logic rd, input int dly,
                       input bit gaps, input int ls_at,
                       input int fs_at);
    int i;
    int cyc;
    bit drove;
    bit ur_exp;
    logic [31:0] dq;
    logic [8:0] wa;
    i = 0; cyc = 0; drove = 0; ur_exp = 0;
    dq = '0; wa = '0;
    @(negedge clk);
    frame_start = 0;
    line_start = 0;
    for (int w = 0; w <= dly; w++) begin
      if (w > 0) @(negedge clk);
      checks++;
      if (bus.mem_valid !== 1'b1 || bus.mem_addr !== a ||
          bus.mem_len !== 8'hFF) begin
        errors++;
        $display("FAIL req: valid %b addr %h len %h want 1 %h ff",
                 bus.mem_valid, bus.mem_addr, bus.mem_len, a);
      end
      checks++;
      if (busy !== 1'b1 || rd_half !== rd || underrun !== 1'b0) begin
        errors++;
        $display("FAIL req_state: busy %b rd %b ur %b want 1 %b 0",
                 busy, rd_half, underrun, rd);
      end
      bus.mem_ready = (w == dly);
    end
    @(negedge clk);
    bus.mem_ready = 0;
    checks++;
    if (bus.mem_valid !== 1'b0) begin
      errors++;
      $display("FAIL req_drop: valid %b want 0", bus.mem_valid);
    end
    while (cyc < 2000) begin
      checks++;
      if (drove) begin
        if (bus.buf_wren !== 1'b1 || bus.buf_waddr !== wa ||
            bus.buf_wdata !== dq) begin
          errors++;
          $display("FAIL write: wren %b addr %h data %h want 1 %h %h",
                   bus.buf_wren, bus.buf_waddr, bus.buf_wdata, wa, dq);
        end
      end else if (bus.buf_wren !== 1'b0) begin
        errors++;
        $display("FAIL no_write: wren %b want 0", bus.buf_wren);
      end
      if (i == 256 && !drove) break;
      checks++;
      if (underrun !== ur_exp || rd_half !== rd || busy !== 1'b1) begin
        errors++;
        $display("FAIL data_state: ur %b rd %b busy %b want %b %b 1",
                 underrun, rd_half, busy, ur_exp, rd);
      end
      ur_exp = 0;
      drove = 0;
      frame_start = 0;
      line_start = 0;
      bus.mem_data_valid = 0;
      if (i < 256 && !(gaps && (cyc % 3 == 1))) begin
        dq = {a[15:0], 16'(i)};
        wa = {h, 8'(i)};
        bus.mem_data = dq;
        bus.mem_data_valid = 1;
        drove = 1;
        if (i == ls_at) begin
          line_start = 1;
          ur_exp = 1;
        end
        if (i == fs_at) frame_start = 1;
        i++;
      end
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (busy !== 1'b0 || i != 256) begin
      errors++;
      $display("FAIL burst_end: busy %b beats %0d want 0 256", busy, i);
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.mem_addr !== 24'h0) begin
      errors++;
      $display("FAIL reset_req: valid %b addr %h want 0 0",
               bus.mem_valid, bus.mem_addr);
    end
    checks++;
    if (bus.buf_wren !== 1'b0 || bus.buf_waddr !== 9'h0 ||
        bus.buf_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_buf: wren %b addr %h data %h want 0 0 0",
               bus.buf_wren, bus.buf_waddr, bus.buf_wdata);
    end
    checks++;
    if (rd_half !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: rd %b busy %b ur %b want 0 0 0",
               rd_half, busy, underrun);
    end
    rst = 0;
    @(negedge clk);
  endtask

  task automatic test_frame_fetch();
    fb_base = 24'h001000;
    frame_start = 1;
    burst(24'h001000, 1'b0, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_line_fetch();
    line_stride = 24'h000140;
    line_start = 1;
    burst(24'h001140, 1'b1, 1'b0, 0, 0, -1, -1);
    line_start = 1;
    burst(24'h001280, 1'b0, 1'b1, 0, 0, -1, -1);
  endtask

  task automatic test_underrun();
    line_start = 1;
    burst(24'h0013C0, 1'b1, 1'b0, 0, 0, 100, -1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (bus.mem_valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL ur_no_req: valid %b busy %b want 0 0",
                 bus.mem_valid, busy);
      end
    end
  endtask

  task automatic test_gaps();
    line_start = 1;
    burst(24'h001500, 1'b0, 1'b1, 5, 1, -1, -1);
  endtask

  task automatic test_same_cycle();
    fb_base = 24'h003000;
    frame_start = 1;
    line_start = 1;
    burst(24'h003000, 1'b0, 1'b1, 0, 0, -1, -1);
  endtask

  task automatic test_frame_midburst();
    fb_base = 24'h002000;
    line_start = 1;
    burst(24'h003140, 1'b1, 1'b0, 0, 0, -1, 50);
    burst(24'h002000, 1'b0, 1'b0, 0, 0, -1, -1);
  endtask

  task automatic test_rst_midburst();
    line_start = 1;
    burst(24'h002140, 1'b1, 1'b0, 0, 0, -1, -1);
    line_start = 1;
    @(negedge clk);
    line_start = 0;
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 24'h002280 ||
        rd_half !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: valid %b addr %h rd %b want 1 002280 1",
               bus.mem_valid, bus.mem_addr, rd_half);
    end
    bus.mem_ready = 1;
    @(negedge clk);
    bus.mem_ready = 0;
    for (int j = 0; j < 30; j++) begin
      bus.mem_data = 32'h5A00_0000 + 32'(j);
      bus.mem_data_valid = 1;
      @(negedge clk);
      checks++;
      if (bus.buf_wren !== 1'b1 || bus.buf_waddr !== {1'b0, 8'(j)}) begin
        errors++;
        $display("FAIL rst_pre_wr: wren %b addr %h want 1 %h",
                 bus.buf_wren, bus.buf_waddr, {1'b0, 8'(j)});
      end
    end
    bus.mem_data = 32'hDEAD_BEEF;
    rst = 1;
    @(negedge clk);
    rst = 0;
    checks++;
    if (bus.mem_valid !== 1'b0 || bus.mem_addr !== 24'h0 ||
        bus.buf_wren !== 1'b0 || bus.buf_waddr !== 9'h0 ||
        bus.buf_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_bus: v %b a %h wr %b wa %h wd %h want zeros",
               bus.mem_valid, bus.mem_addr, bus.buf_wren,
               bus.buf_waddr, bus.buf_wdata);
    end
    checks++;
    if (rd_half !== 1'b0 || busy !== 1'b0 || underrun !== 1'b0) begin
      errors++;
      $display("FAIL rst_flags: rd %b busy %b ur %b want 0 0 0",
               rd_half, busy, underrun);
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (bus.buf_wren !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rst_stale_beat: wren %b busy %b want 0 0",
                 bus.buf_wren, busy);
      end
    end
    bus.mem_data_valid = 0;
    line_start = 1;
    @(negedge clk);
    line_start = 0;
    checks++;
    if (bus.mem_valid !== 1'b1 || bus.mem_addr !== 24'h000140 ||
        rd_half !== 1'b0) begin
      errors++;
      $display("FAIL rst_post: valid %b addr %h rd %b want 1 000140 0",
               bus.mem_valid, bus.mem_addr, rd_half);
    end
  endtask

  initial begin
    bus.mem_ready = 0;
    bus.mem_data = '0;
    bus.mem_data_valid = 0;
    test_reset();
    test_frame_fetch();
    test_line_fetch();
    test_underrun();
    test_gaps();
    test_same_cycle();
    test_frame_midburst();
    test_rst_midburst();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
